// File: rtl/sparse24_pkg.sv
// Shared definitions for the 2:4 structured-sparsity compressor and decompressor.
// Lane/keep counts, default element width and a signed magnitude helper.
package sparse24_pkg;

  localparam int unsigned LANES     = 4;
  localparam int unsigned KEEP      = 2;
  localparam int unsigned DEFAULT_W = 16;
  localparam int unsigned MAG_W     = 32;

  // Caller sign-extends its element to MAG_W and truncates the result back to its
  // own width; |-2^(W-1)| = 2^(W-1) still fits as a W-bit unsigned value.
  function automatic logic [MAG_W-1:0] mag(input logic [MAG_W-1:0] x);
    return x[MAG_W-1] ? -x : x;
  endfunction

endpackage

// File: rtl/sparse24_topk_sel.sv
// Combinational 2-of-4 selector: keeps the two largest-magnitude lanes (lower index
// wins ties), packs them low-index-first into the MSB half and counts nonzero drops.
module sparse24_topk_sel
  import sparse24_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic [LANES*W-1:0] i_dense,
  output logic [LANES-1:0]   o_mask,
  output logic [2*W-1:0]     o_pair,
  output logic [1:0]         o_pruned
);

  logic [W-1:0]     w_lane [LANES];
  logic [W-1:0]     w_mag  [LANES];
  logic [LANES-1:0] w_keep;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane[i] = i_dense[i*W +: W];
      w_mag[i]  = W'(mag(MAG_W'($signed(w_lane[i]))));
    end
  end

  // A lane survives when fewer than KEEP other lanes beat it; the index tie-break
  // makes the ordering total, so exactly KEEP lanes survive for any input.
  always_comb begin
    logic [2:0] beats;
    beats  = '0;
    w_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      beats = '0;
      for (int j = 0; j < LANES; j++) begin
        if (j != i) begin
          if ((w_mag[j] > w_mag[i]) || ((w_mag[j] == w_mag[i]) && (j < i))) begin
            beats = beats + 3'd1;
          end
        end
      end
      w_keep[i] = (beats < 3'(KEEP));
    end
  end

  always_comb begin
    logic found;
    found    = 1'b0;
    o_pair   = '0;
    o_pruned = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_keep[i]) begin
        if (!found) begin
          o_pair[W +: W] = w_lane[i];
          found          = 1'b1;
        end else begin
          o_pair[0 +: W] = w_lane[i];
        end
      end else if (w_lane[i] != '0) begin
        o_pruned = o_pruned + 2'd1;
      end
    end
  end

  assign o_mask = w_keep;

endmodule

// File: rtl/compressor_2to4.sv
// Streaming 2:4 compressor: selector feeding a 2-stage valid/ready pipeline, plus a
// saturating count of nonzero values lost to pruning.
module compressor_2to4
  import sparse24_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  output logic               in_ready,
  input  logic [LANES*W-1:0] dense_vals,
  output logic               valid_out,
  input  logic               out_ready,
  output logic [2*W-1:0]     packed_vals,
  output logic [LANES-1:0]   mask,
  input  logic               clr_stats,
  output logic [15:0]        pruned_cnt
);

  logic [LANES-1:0] w_sel_mask;
  logic [2*W-1:0]   w_sel_pair;
  logic [1:0]       w_sel_pruned;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_in_fire;
  logic [16:0]      w_cnt_sum;
  logic [15:0]      w_cnt_d;

  logic             r_s1_valid;
  logic [LANES-1:0] r_s1_mask;
  logic [2*W-1:0]   r_s1_pair;
  logic             r_s2_valid;
  logic [LANES-1:0] r_s2_mask;
  logic [2*W-1:0]   r_s2_pair;
  logic [15:0]      r_cnt;

  sparse24_topk_sel #(
    .W (W)
  ) u_sel (
    .i_dense  (dense_vals),
    .o_mask   (w_sel_mask),
    .o_pair   (w_sel_pair),
    .o_pruned (w_sel_pruned)
  );

  // Each stage may load whenever the stage after it is empty or draining this cycle.
  assign w_adv2    = !r_s2_valid || out_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign w_in_fire = valid_in && w_adv1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mask  <= '0;
      r_s1_pair  <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= valid_in;
      if (valid_in) begin
        r_s1_mask <= w_sel_mask;
        r_s1_pair <= w_sel_pair;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_mask  <= '0;
      r_s2_pair  <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mask <= r_s1_mask;
        r_s2_pair <= r_s1_pair;
      end
    end
  end

  always_comb begin
    w_cnt_sum = {1'b0, r_cnt} + {15'd0, w_sel_pruned};
    w_cnt_d   = r_cnt;
    if (clr_stats) begin
      w_cnt_d = '0;
    end else if (w_in_fire) begin
      w_cnt_d = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign in_ready    = w_adv1;
  assign valid_out   = r_s2_valid;
  assign packed_vals = r_s2_pair;
  assign mask        = r_s2_mask;
  assign pruned_cnt  = r_cnt;

endmodule
